// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-port unified memory between the instruction-fetch and data ports.
// Data wins contention until the starvation counter forces a fetch grant.
module riscv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_arb_if_req,
    input  logic [XLEN-1:0] i_arb_if_addr,
    output logic [XLEN-1:0] o_arb_if_rdata,
    output logic            o_arb_if_valid,
    output logic            o_arb_if_stall,
    input  logic            i_arb_d_req,
    input  logic            i_arb_d_wr_en,
    input  logic [XLEN-1:0] i_arb_d_addr,
    input  logic [XLEN-1:0] i_arb_d_wdata,
    input  logic [3:0]      i_arb_d_byte_sel,
    output logic [XLEN-1:0] o_arb_d_rdata,
    output logic            o_arb_d_valid,
    output logic            o_arb_d_stall,
    output logic            o_arb_mem_req,
    output logic [XLEN-1:0] o_arb_mem_addr,
    output logic            o_arb_mem_wr_en,
    output logic [XLEN-1:0] o_arb_mem_wdata,
    output logic [3:0]      o_arb_mem_byte_sel,
    input  logic            i_arb_mem_ack,
    input  logic [XLEN-1:0] i_arb_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic       w_grant_if;
    logic       w_grant_d;

    // Grant selection and next state; a completing port is only offered to the other side.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_arb_if_req && i_arb_d_req) begin
                    if (r_starve_cnt == LIMIT) begin
                        w_grant_if = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (i_arb_if_req) begin
                    w_grant_if = 1'b1;
                end else if (i_arb_d_req) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY_IF: begin
                if (i_arb_mem_ack) begin
                    if (i_arb_d_req) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = BUSY_IF;
                end
            end
            BUSY_D: begin
                if (i_arb_mem_ack) begin
                    if (i_arb_if_req) begin
                        w_grant_if = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = BUSY_D;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_grant_if) begin
            w_state_nxt = BUSY_IF;
        end else if (w_grant_d) begin
            w_state_nxt = BUSY_D;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Starvation counter: counts data grants that beat a waiting fetch, saturating at the limit.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_d) begin
            if (i_arb_if_req) begin
                if (r_starve_cnt < LIMIT) begin
                    w_starve_nxt = r_starve_cnt + 4'd1;
                end else begin
                    w_starve_nxt = LIMIT;
                end
            end else begin
                w_starve_nxt = 4'd0;
            end
        end else if (w_grant_if) begin
            w_starve_nxt = 4'd0;
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // State, counter and the registered memory request fields.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state            <= IDLE;
            r_starve_cnt       <= 4'd0;
            o_arb_mem_req      <= 1'b0;
            o_arb_mem_addr     <= '0;
            o_arb_mem_wr_en    <= 1'b0;
            o_arb_mem_wdata    <= '0;
            o_arb_mem_byte_sel <= 4'b0000;
        end else begin
            r_state       <= w_state_nxt;
            r_starve_cnt  <= w_starve_nxt;
            o_arb_mem_req <= (w_state_nxt != IDLE);
            if (w_grant_if) begin
                o_arb_mem_addr     <= i_arb_if_addr;
                o_arb_mem_wr_en    <= 1'b0;
                o_arb_mem_wdata    <= '0;
                o_arb_mem_byte_sel <= 4'b0000;
            end else if (w_grant_d) begin
                o_arb_mem_addr     <= i_arb_d_addr;
                o_arb_mem_wr_en    <= i_arb_d_wr_en;
                o_arb_mem_wdata    <= i_arb_d_wdata;
                // loads never carry byte enables to the memory
                o_arb_mem_byte_sel <= i_arb_d_wr_en ? i_arb_d_byte_sel : 4'b0000;
            end else begin
                o_arb_mem_addr     <= o_arb_mem_addr;
                o_arb_mem_wr_en    <= o_arb_mem_wr_en;
                o_arb_mem_wdata    <= o_arb_mem_wdata;
                o_arb_mem_byte_sel <= o_arb_mem_byte_sel;
            end
        end
    end

    assign o_arb_if_valid = (r_state == BUSY_IF) && i_arb_mem_ack;
    assign o_arb_d_valid  = (r_state == BUSY_D) && i_arb_mem_ack;
    assign o_arb_if_rdata = i_arb_mem_rdata;
    assign o_arb_d_rdata  = i_arb_mem_rdata;
    assign o_arb_if_stall = i_arb_if_req & ~o_arb_if_valid;
    assign o_arb_d_stall  = i_arb_d_req & ~o_arb_d_valid;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized scoreboard bench for riscv_mem_arbiter: a transaction-level model predicts
// grants and completions, a negedge monitor compares them against the DUT.
module tb_riscv_mem_arbiter;
    localparam int XLEN = 32;
    localparam int LIM  = 2;

    logic            i_clk;
    logic            i_rst;
    logic            i_arb_if_req;
    logic [XLEN-1:0] i_arb_if_addr;
    logic [XLEN-1:0] o_arb_if_rdata;
    logic            o_arb_if_valid;
    logic            o_arb_if_stall;
    logic            i_arb_d_req;
    logic            i_arb_d_wr_en;
    logic [XLEN-1:0] i_arb_d_addr;
    logic [XLEN-1:0] i_arb_d_wdata;
    logic [3:0]      i_arb_d_byte_sel;
    logic [XLEN-1:0] o_arb_d_rdata;
    logic            o_arb_d_valid;
    logic            o_arb_d_stall;
    logic            o_arb_mem_req;
    logic [XLEN-1:0] o_arb_mem_addr;
    logic            o_arb_mem_wr_en;
    logic [XLEN-1:0] o_arb_mem_wdata;
    logic [3:0]      o_arb_mem_byte_sel;
    logic            i_arb_mem_ack;
    logic [XLEN-1:0] i_arb_mem_rdata;

    riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_arb_if_req(i_arb_if_req), .i_arb_if_addr(i_arb_if_addr),
        .o_arb_if_rdata(o_arb_if_rdata), .o_arb_if_valid(o_arb_if_valid),
        .o_arb_if_stall(o_arb_if_stall),
        .i_arb_d_req(i_arb_d_req), .i_arb_d_wr_en(i_arb_d_wr_en),
        .i_arb_d_addr(i_arb_d_addr), .i_arb_d_wdata(i_arb_d_wdata),
        .i_arb_d_byte_sel(i_arb_d_byte_sel), .o_arb_d_rdata(o_arb_d_rdata),
        .o_arb_d_valid(o_arb_d_valid), .o_arb_d_stall(o_arb_d_stall),
        .o_arb_mem_req(o_arb_mem_req), .o_arb_mem_addr(o_arb_mem_addr),
        .o_arb_mem_wr_en(o_arb_mem_wr_en), .o_arb_mem_wdata(o_arb_mem_wdata),
        .o_arb_mem_byte_sel(o_arb_mem_byte_sel), .i_arb_mem_ack(i_arb_mem_ack),
        .i_arb_mem_rdata(i_arb_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          port;   // 1 = fetch, 2 = data
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  bsel;
    } txn_t;

    typedef struct {
        int          port;
        logic        chk;
        logic [31:0] rdata;
    } cpl_t;

    txn_t gq[$];
    cpl_t cq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] phys [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    int   m_owner, nxt_owner, m_cnt, nxt_cnt, m_wait, nxt_wait;
    txn_t m_t, nxt_t;
    bit   exp_if_v, exp_d_v, if_done, d_done, mon_en;
    int   if_rate, d_rate;

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] bs);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (bs[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] phys_rd(logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_word(a);
    endfunction

    function automatic logic [31:0] pick_addr();
        return 32'h0000_1000 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: hand the memory to port p at the coming edge.
    task automatic grant(int p);
        txn_t t;
        if (p == 1) begin
            t.port = 1; t.addr = i_arb_if_addr; t.wr = 1'b0; t.wdata = 32'h0; t.bsel = 4'b0000;
            nxt_cnt = 0;
        end else begin
            t.port = 2; t.addr = i_arb_d_addr; t.wr = i_arb_d_wr_en; t.wdata = i_arb_d_wdata;
            t.bsel = i_arb_d_wr_en ? i_arb_d_byte_sel : 4'b0000;
            nxt_cnt = i_arb_if_req ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
        end
        nxt_owner = p;
        nxt_t     = t;
        nxt_wait  = $urandom_range(0, 3);
        gq.push_back(t);
    endtask

    // One clock cycle: commit model, drive requesters and memory, predict the next edge.
    task automatic step();
        cpl_t c;
        bit   if_p, d_p;
        @(posedge i_clk);
        #1;
        m_owner = nxt_owner; m_cnt = nxt_cnt; m_t = nxt_t; m_wait = nxt_wait;
        if (if_done) begin i_arb_if_req = 1'b0; if_done = 1'b0; end
        if (d_done)  begin i_arb_d_req  = 1'b0; d_done  = 1'b0; end
        if (!i_arb_if_req && $urandom_range(0, 99) < if_rate) begin
            i_arb_if_req  = 1'b1;
            i_arb_if_addr = pick_addr();
        end
        if (!i_arb_d_req && $urandom_range(0, 99) < d_rate) begin
            i_arb_d_req      = 1'b1;
            i_arb_d_wr_en    = ($urandom_range(0, 2) == 0);
            i_arb_d_addr     = pick_addr();
            i_arb_d_wdata    = $urandom;
            i_arb_d_byte_sel = 4'($urandom_range(0, 15));
        end
        // memory: acks after a random wait, also throws occasional spurious acks when idle
        i_arb_mem_rdata = $urandom;
        if (m_owner != 0) begin
            i_arb_mem_ack = (m_wait == 0);
            if (m_wait > 0) m_wait--;
            if (i_arb_mem_ack) begin
                i_arb_mem_rdata = phys_rd(o_arb_mem_addr);
                if (o_arb_mem_wr_en)
                    phys[o_arb_mem_addr] = merge(phys_rd(o_arb_mem_addr), o_arb_mem_wdata, o_arb_mem_byte_sel);
            end
        end else begin
            i_arb_mem_ack = ($urandom_range(0, 19) == 0);
        end
        exp_if_v = 1'b0; exp_d_v = 1'b0;
        nxt_owner = m_owner; nxt_cnt = m_cnt; nxt_t = m_t; nxt_wait = m_wait;
        if_p = i_arb_if_req; d_p = i_arb_d_req;
        if (m_owner == 0) begin
            if (if_p && d_p) grant((m_cnt == LIM) ? 1 : 2);
            else if (if_p)   grant(1);
            else if (d_p)    grant(2);
        end else if (i_arb_mem_ack) begin
            c.port  = m_owner;
            c.chk   = !m_t.wr;
            c.rdata = ref_rd(m_t.addr);
            if (m_t.wr) refm[m_t.addr] = merge(ref_rd(m_t.addr), m_t.wdata, m_t.bsel);
            cq.push_back(c);
            if (m_owner == 1) begin
                exp_if_v = 1'b1; if_done = 1'b1;
                if (d_p) grant(2); else nxt_owner = 0;
            end else begin
                exp_d_v = 1'b1; d_done = 1'b1;
                if (if_p) grant(1); else nxt_owner = 0;
            end
        end
    endtask

    // Monitor: compares DUT behaviour against the queued expectations, away from the edge.
    bit prev_req = 1'b0;
    bit prev_ack = 1'b0;
    always @(negedge i_clk) begin
        cpl_t c;
        txn_t t;
        if (mon_en) begin
            check("mem_req", 32'(o_arb_mem_req), 32'(m_owner != 0));
            check("if_valid", 32'(o_arb_if_valid), 32'(exp_if_v));
            check("d_valid", 32'(o_arb_d_valid), 32'(exp_d_v));
            check("if_stall", 32'(o_arb_if_stall), 32'(i_arb_if_req && !exp_if_v));
            check("d_stall", 32'(o_arb_d_stall), 32'(i_arb_d_req && !exp_d_v));
            if (o_arb_if_valid || o_arb_d_valid) begin
                if (cq.size() == 0) begin
                    check("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    c = cq.pop_front();
                    check("cpl_port", o_arb_if_valid ? 32'd1 : 32'd2, 32'(c.port));
                    if (c.chk) check("cpl_rdata", (c.port == 1) ? o_arb_if_rdata : o_arb_d_rdata, c.rdata);
                end
            end
            if (o_arb_mem_req && (!prev_req || prev_ack)) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 32'd1, 32'd0);
                end else begin
                    t = gq.pop_front();
                    check("mem_addr", o_arb_mem_addr, t.addr);
                    check("mem_wr_en", 32'(o_arb_mem_wr_en), 32'(t.wr));
                    check("mem_byte_sel", 32'(o_arb_mem_byte_sel), 32'(t.bsel));
                    if (t.wr) check("mem_wdata", o_arb_mem_wdata, t.wdata);
                end
            end
        end
        prev_req = o_arb_mem_req;
        prev_ack = i_arb_mem_ack;
    end

    initial begin
        int guard;
        i_rst = 1'b1;
        i_arb_if_req = 1'b0; i_arb_if_addr = 32'h0;
        i_arb_d_req = 1'b0; i_arb_d_wr_en = 1'b0; i_arb_d_addr = 32'h0;
        i_arb_d_wdata = 32'h0; i_arb_d_byte_sel = 4'b0000;
        i_arb_mem_ack = 1'b0; i_arb_mem_rdata = 32'h0;
        m_owner = 0; nxt_owner = 0; m_cnt = 0; nxt_cnt = 0; m_wait = 0; nxt_wait = 0;
        if_done = 1'b0; d_done = 1'b0; mon_en = 1'b0; exp_if_v = 1'b0; exp_d_v = 1'b0;
        #1;
        check("rst_mem_req", 32'(o_arb_mem_req), 32'd0);
        check("rst_mem_addr", o_arb_mem_addr, 32'h0);
        check("rst_mem_wr_en", 32'(o_arb_mem_wr_en), 32'd0);
        check("rst_mem_byte_sel", 32'(o_arb_mem_byte_sel), 32'd0);
        check("rst_valids", 32'({o_arb_if_valid, o_arb_d_valid}), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        mon_en = 1'b1;

        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin if_rate = 40;  d_rate = 40;  end
                1: begin if_rate = 100; d_rate = 100; end
                2: begin if_rate = 10;  d_rate = 70;  end
                default: begin if_rate = 80; d_rate = 20; end
            endcase
            repeat (800) step();
        end

        if_rate = 0; d_rate = 0;
        guard = 0;
        while (!(m_owner == 0 && nxt_owner == 0 && !i_arb_if_req && !i_arb_d_req) && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
        @(negedge i_clk);
        #1;
        mon_en = 1'b0;
        check("grant_queue_empty", 32'(gq.size()), 32'd0);
        check("cpl_queue_empty", 32'(cq.size()), 32'd0);

        // reset in the middle of a slow load: aborts, and the late ack is ignored
        i_arb_mem_ack = 1'b0;
        @(posedge i_clk); #1;
        i_arb_d_req = 1'b1; i_arb_d_wr_en = 1'b0; i_arb_d_addr = 32'h0000_0040; i_arb_d_byte_sel = 4'hF;
        @(posedge i_clk); #1;
        check("rst_test_req_up", 32'(o_arb_mem_req), 32'd1);
        check("rst_test_addr", o_arb_mem_addr, 32'h0000_0040);
        check("rst_test_load_bsel", 32'(o_arb_mem_byte_sel), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1; i_arb_d_req = 1'b0;
        #1;
        check("rst_test_async_req", 32'(o_arb_mem_req), 32'd0);
        check("rst_test_async_addr", o_arb_mem_addr, 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_arb_mem_ack = 1'b1; i_arb_mem_rdata = 32'hCAFE_F00D;
        #1;
        check("late_ack_d_valid", 32'(o_arb_d_valid), 32'd0);
        check("late_ack_if_valid", 32'(o_arb_if_valid), 32'd0);
        @(posedge i_clk); #1;
        i_arb_mem_ack = 1'b0;
        check("late_ack_no_req", 32'(o_arb_mem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
